// File: rtl/stack_exec_ctrl.sv
// stack_exec_ctrl: command sequencer and ALU for a shift-register stack.
// Turns one calculator command into move/mode/push_word strobes.
module stack_exec_ctrl #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [2:0]                 cmd_op,
  input  logic [WIDTH-1:0]           cmd_imm,
  input  logic [WIDTH-1:0]           top_word,
  input  logic [WIDTH-1:0]           second_word,
  output logic                       move,
  output logic                       mode,
  output logic [WIDTH-1:0]           push_word,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       carry,
  output logic                       err,
  input  logic                       err_clr
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] DMAX = DW'(DEPTH);
  localparam logic [DW-1:0] DTWO = DW'(2);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_DUP  = 3'd6;
  localparam logic [2:0] OP_SWAP = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP1,
    S_POP2,
    S_PUSH1,
    S_PUSH2
  } state_t;

  state_t           state_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             move_q;
  logic             mode_q;
  logic [WIDTH-1:0] pw_q;
  logic [DW-1:0]    depth_q;
  logic             carry_q;
  logic             err_q;
  logic             err_d;

  logic             accept;
  logic             legal;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic [WIDTH-1:0] alu_res;

  assign cmd_ready = (state_q == S_IDLE);
  assign accept    = cmd_valid && cmd_ready;

  assign move      = move_q;
  assign mode      = mode_q;
  assign push_word = pw_q;
  assign depth     = depth_q;
  assign carry     = carry_q;
  assign err       = err_q;

  // Operand arithmetic on the live stack words (opA=top, opB=second).
  always_comb begin
    sum     = {1'b0, second_word} + {1'b0, top_word};
    diff    = second_word - top_word;
    borrow  = (second_word < top_word);
    alu_res = '0;
    case (cmd_op)
      OP_ADD:  alu_res = sum[WIDTH-1:0];
      OP_SUB:  alu_res = diff;
      OP_AND:  alu_res = second_word & top_word;
      default: alu_res = '0;
    endcase
  end

  // Depth-based legality of the command presented in IDLE.
  always_comb begin
    legal = 1'b1;
    case (cmd_op)
      OP_NOP:  legal = 1'b1;
      OP_PUSH: legal = (depth_q < DMAX);
      OP_POP:  legal = (depth_q != '0);
      OP_ADD,
      OP_SUB,
      OP_AND,
      OP_SWAP: legal = (depth_q >= DTWO);
      OP_DUP:  legal = (depth_q != '0) && (depth_q < DMAX);
      default: legal = 1'b1;
    endcase
  end

  // Sequencer FSM with registered move/mode/push_word strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      move_q  <= 1'b0;
      mode_q  <= 1'b0;
      pw_q    <= '0;
      carry_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          move_q <= 1'b0;
          mode_q <= 1'b0;
          pw_q   <= '0;
          if (accept && legal) begin
            op_q  <= cmd_op;
            a_q   <= top_word;
            b_q   <= second_word;
            res_q <= alu_res;
            case (cmd_op)
              OP_PUSH: begin
                state_q <= S_PUSH1;
                move_q  <= 1'b1;
                mode_q  <= 1'b1;
                pw_q    <= cmd_imm;
              end
              OP_DUP: begin
                state_q <= S_PUSH1;
                move_q  <= 1'b1;
                mode_q  <= 1'b1;
                pw_q    <= top_word;
              end
              OP_POP,
              OP_SWAP: begin
                state_q <= S_POP1;
                move_q  <= 1'b1;
              end
              OP_ADD: begin
                state_q <= S_POP1;
                move_q  <= 1'b1;
                carry_q <= sum[WIDTH];
              end
              OP_SUB: begin
                state_q <= S_POP1;
                move_q  <= 1'b1;
                carry_q <= borrow;
              end
              OP_AND: begin
                state_q <= S_POP1;
                move_q  <= 1'b1;
              end
              default: state_q <= S_IDLE;
            endcase
          end
        end
        S_POP1: begin
          if (op_q == OP_POP) begin
            state_q <= S_IDLE;
            move_q  <= 1'b0;
          end else begin
            state_q <= S_POP2;
            move_q  <= 1'b1;
            mode_q  <= 1'b0;
          end
        end
        S_POP2: begin
          state_q <= S_PUSH1;
          move_q  <= 1'b1;
          mode_q  <= 1'b1;
          pw_q    <= (op_q == OP_SWAP) ? a_q : res_q;
        end
        S_PUSH1: begin
          if (op_q == OP_SWAP) begin
            state_q <= S_PUSH2;
            move_q  <= 1'b1;
            mode_q  <= 1'b1;
            pw_q    <= b_q;
          end else begin
            state_q <= S_IDLE;
            move_q  <= 1'b0;
            mode_q  <= 1'b0;
            pw_q    <= '0;
          end
        end
        S_PUSH2: begin
          state_q <= S_IDLE;
          move_q  <= 1'b0;
          mode_q  <= 1'b0;
          pw_q    <= '0;
        end
        default: begin
          state_q <= S_IDLE;
          move_q  <= 1'b0;
          mode_q  <= 1'b0;
          pw_q    <= '0;
        end
      endcase
    end
  end

  // Depth follows every stack movement the strobes cause.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth_q <= '0;
    end else if (move_q) begin
      depth_q <= mode_q ? depth_q + 1'b1 : depth_q - 1'b1;
    end
  end

  // Sticky error; a clear wins over a new error on the same edge.
  always_comb begin
    err_d = err_q | (accept & ~legal);
    if (err_clr) err_d = 1'b0;
  end

  // Error flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

endmodule

// File: tb/tb_stack_exec_ctrl.sv
// tb_stack_exec_ctrl: directed bench with a behavioural 4x8 stack.
// Expected values are hand-computed per scenario.
module tb_stack_exec_ctrl;

  localparam int W = 4;
  localparam int D = 8;

  logic         clk = 0;
  logic         rst = 1;
  logic         cmd_valid = 0;
  logic         cmd_ready;
  logic [2:0]   cmd_op = 0;
  logic [W-1:0] cmd_imm = 0;
  logic [W-1:0] top_word;
  logic [W-1:0] second_word;
  logic         move;
  logic         mode;
  logic [W-1:0] push_word;
  logic [3:0]   depth;
  logic         carry;
  logic         err;
  logic         err_clr = 0;

  int total = 0;
  int bad = 0;

  logic [W-1:0] stk [D];
  logic [W:0]   mlog [$];

  always #5 clk = ~clk;

  stack_exec_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_imm(cmd_imm),
    .top_word(top_word), .second_word(second_word),
    .move(move), .mode(mode), .push_word(push_word),
    .depth(depth), .carry(carry), .err(err),
    .err_clr(err_clr)
  );

  // Behavioural stack register driven by the strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < D; i++) stk[i] <= '0;
    end else if (move) begin
      if (mode) begin
        stk[0] <= push_word;
        for (int i = 1; i < D; i++) stk[i] <= stk[i-1];
      end else begin
        for (int i = 0; i < D-1; i++) stk[i] <= stk[i+1];
        stk[D-1] <= '0;
      end
    end
  end
  assign top_word    = stk[0];
  assign second_word = stk[1];

  // Log every move pulse as {mode, push_word}.
  always @(negedge clk) if (!rst && move) mlog.push_back({mode, push_word});

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(output int busy);
    busy = 0;
    @(negedge clk);
    while (!cmd_ready && busy < 20) begin
      busy++;
      @(negedge clk);
    end
    if (!cmd_ready) chk("timeout", 0, 1);
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] imm);
    int b;
    wait_idle(b);
    cmd_op = op;
    cmd_imm = imm;
    cmd_valid = 1;
    @(posedge clk);
    #1 cmd_valid = 0;
  endtask

  task automatic run(input logic [2:0] op, input logic [W-1:0] imm, output int busy);
    issue(op, imm);
    wait_idle(busy);
  endtask

  task automatic do_reset();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    mlog.delete();
  endtask

  int b;

  initial begin
    do_reset();
    rst = 1;
    @(negedge clk);
    chk("rst_move", move, 0);
    chk("rst_mode", mode, 0);
    chk("rst_pw", push_word, 0);
    chk("rst_depth", depth, 0);
    chk("rst_carry", carry, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", cmd_ready, 1);
    rst = 0;

    // 1: 3 + 5
    run(3'd1, 4'd3, b);
    run(3'd1, 4'd5, b);
    mlog.delete();
    issue(3'd3, 0);
    wait_idle(b);
    chk("t1_busy", b, 3);
    chk("t1_nmoves", mlog.size(), 3);
    if (mlog.size() == 3) begin
      chk("t1_m0", mlog[0][W], 0);
      chk("t1_m1", mlog[1][W], 0);
      chk("t1_m2", mlog[2], 5'h18);
    end
    chk("t1_top", top_word, 8);
    chk("t1_depth", depth, 1);
    chk("t1_carry", carry, 0);

    // 2: 9 + A carry, then 3 - 5 borrow
    do_reset();
    run(3'd1, 4'h9, b);
    run(3'd1, 4'hA, b);
    run(3'd3, 0, b);
    chk("t2_add_top", top_word, 3);
    chk("t2_add_carry", carry, 1);
    run(3'd1, 4'h5, b);
    run(3'd4, 0, b);
    chk("t2_sub_top", top_word, 4'hE);
    chk("t2_sub_carry", carry, 1);
    chk("t2_depth", depth, 1);

    // 3: swap
    do_reset();
    run(3'd1, 4'd1, b);
    run(3'd1, 4'd2, b);
    mlog.delete();
    run(3'd7, 0, b);
    chk("t3_busy", b, 4);
    chk("t3_nmoves", mlog.size(), 4);
    if (mlog.size() == 4) begin
      chk("t3_m0", mlog[0][W], 0);
      chk("t3_m1", mlog[1][W], 0);
      chk("t3_m2", mlog[2], 5'h12);
      chk("t3_m3", mlog[3], 5'h11);
    end
    chk("t3_top", top_word, 1);
    chk("t3_second", second_word, 2);
    chk("t3_depth", depth, 2);

    // 4: full stack
    do_reset();
    for (int i = 0; i < 8; i++) run(3'd1, 4'(i + 1), b);
    chk("t4_full", depth, 8);
    chk("t4_top", top_word, 8);
    mlog.delete();
    run(3'd1, 4'hF, b);
    chk("t4_ovf_moves", mlog.size(), 0);
    chk("t4_ovf_err", err, 1);
    chk("t4_ovf_depth", depth, 8);
    err_clr = 1;
    @(posedge clk);
    #1 err_clr = 0;
    chk("t4_clr", err, 0);
    run(3'd6, 0, b);
    chk("t4_dup_moves", mlog.size(), 0);
    chk("t4_dup_err", err, 1);
    chk("t4_dup_depth", depth, 8);
    // clear wins over a simultaneous new error
    @(negedge clk);
    cmd_op = 3'd1;
    cmd_valid = 1;
    err_clr = 1;
    @(posedge clk);
    #1 cmd_valid = 0;
    err_clr = 0;
    chk("t4_clr_prio", err, 0);

    // 5: underflow and sticky err
    do_reset();
    mlog.delete();
    run(3'd2, 0, b);
    chk("t5_pop_err", err, 1);
    chk("t5_pop_depth", depth, 0);
    chk("t5_pop_moves", mlog.size(), 0);
    run(3'd1, 4'd4, b);
    mlog.delete();
    run(3'd3, 0, b);
    chk("t5_add_err", err, 1);
    chk("t5_add_moves", mlog.size(), 0);
    chk("t5_add_depth", depth, 1);
    chk("t5_add_top", top_word, 4);
    run(3'd0, 0, b);
    chk("t5_nop_busy", b, 0);
    chk("t5_nop_moves", mlog.size(), 0);
    run(3'd6, 0, b);
    chk("t5_dup_busy", b, 1);
    chk("t5_dup_depth", depth, 2);
    chk("t5_dup_second", second_word, 4);
    run(3'd1, 4'hC, b);
    run(3'd5, 0, b);
    chk("t5_and_top", top_word, 4);
    chk("t5_and_depth", depth, 2);
    chk("t5_and_carry", carry, 0);
    run(3'd2, 0, b);
    chk("t5_pop_busy", b, 1);
    chk("t5_pop_top", top_word, 4);
    chk("t5_pop_d", depth, 1);

    // 6: reset during POP2
    do_reset();
    run(3'd1, 4'hF, b);
    run(3'd1, 4'h1, b);
    issue(3'd3, 0);
    @(posedge clk);
    #1;
    chk("t6_pre_move", move, 1);
    chk("t6_pre_carry", carry, 1);
    rst = 1;
    #1;
    chk("t6_move", move, 0);
    chk("t6_depth", depth, 0);
    chk("t6_ready", cmd_ready, 1);
    chk("t6_carry", carry, 0);
    @(negedge clk);
    rst = 0;
    run(3'd1, 4'd7, b);
    chk("t6_top", top_word, 7);
    chk("t6_d", depth, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
